// File: rtl/max_product_beta_scheduler_if.sv
// Bundle between the beta-recursion scheduler and its environment:
// block control, initial-beta writes, metric reads, unit handshake and write-back steering.
interface max_product_beta_scheduler_if #(
  parameter int STEP_W  = 11,
  parameter int STATE_W = 2,
  parameter int BITS    = 32
);
  logic               start;
  logic [STEP_W-1:0]  block_len;
  logic               busy;
  logic               done;
  logic               err;
  logic               init_we;
  logic [STATE_W-1:0] init_state;
  logic [BITS-1:0]    init_data;
  logic [STEP_W-1:0]  init_step;
  logic               rd_en;
  logic [STEP_W-1:0]  rd_step;
  logic [STATE_W-1:0] rd_state;
  logic               unit_in_valid;
  logic               unit_out_valid;
  logic               beta_we;
  logic               llr_we;
  logic [STEP_W-1:0]  wr_step;
  logic [STATE_W-1:0] wr_state;
  logic [2:0]         fsm_state;

  // Handshake: rd_en issues a read; unit_in_valid follows one cycle later (1-cycle memory);
  // every unit_out_valid pulse is a single in-order result, accepted unconditionally (no ready).
  modport master (
    input  start, block_len, unit_out_valid,
    output busy, done, err, init_we, init_state, init_data, init_step,
           rd_en, rd_step, rd_state, unit_in_valid, beta_we, llr_we,
           wr_step, wr_state, fsm_state
  );

  modport slave (
    output start, block_len, unit_out_valid,
    input  busy, done, err, init_we, init_state, init_data, init_step,
           rd_en, rd_step, rd_state, unit_in_valid, beta_we, llr_we,
           wr_step, wr_state, fsm_state
  );
endinterface

// File: rtl/max_product_beta_scheduler.sv
// Sequencer for the backward (beta) recursion: seeds initial betas, then issues one
// STATES-wide read group per step from block_len-1 down to 0, steering unit returns to writes.
module max_product_beta_scheduler #(
  parameter int STATES     = 4,
  parameter int MAX_LEN    = 1024,
  parameter int STEP_W     = $clog2(MAX_LEN + 1),
  parameter int STATE_W    = $clog2(STATES),
  parameter int BITS       = 32,
  parameter int TERMINATED = 1
) (
  input  logic clk,
  input  logic reset_n,
  max_product_beta_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [BITS-1:0]    ONE      = BITS'(32'h3F80_0000);
  localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(STATES - 1);
  localparam logic [STATE_W:0]   ALL_RET  = (STATE_W + 1)'(STATES);

  state_t             state_q, state_d;
  logic [STATE_W-1:0] idx_q;
  logic [STATE_W:0]   ret_q;
  logic [STATE_W:0]   outst_q;
  logic [STEP_W-1:0]  len_q;
  logic [STEP_W-1:0]  step_q;
  logic               in_valid_q;
  logic               err_q;
  logic               armed_q;

  logic accept, idx_last, ret_ok, spurious, group_done;

  assign accept     = (state_q == S_IDLE) && bus.start;
  assign idx_last   = (idx_q == LAST_IDX);
  assign ret_ok     = bus.unit_out_valid && (outst_q != '0);
  // armed_q stays low after reset so results still in flight from an aborted block are dropped silently
  assign spurious   = bus.unit_out_valid && (outst_q == '0) && armed_q;
  assign group_done = (state_q == S_WAIT) && (ret_q == ALL_RET) && (outst_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_INIT;
      S_INIT:  if (idx_last) state_d = (len_q == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (idx_last) state_d = S_WAIT;
      S_WAIT:  if (group_done) state_d = (step_q == '0) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q      <= '0;
      ret_q      <= '0;
      outst_q    <= '0;
      len_q      <= '0;
      step_q     <= '0;
      in_valid_q <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      if (accept) len_q <= bus.block_len;

      if ((state_q == S_INIT) || (state_q == S_ISSUE))
        idx_q <= idx_last ? '0 : idx_q + 1'b1;
      else
        idx_q <= '0;

      if ((state_q == S_INIT) && idx_last && (len_q != '0))
        step_q <= len_q - 1'b1;
      else if (group_done && (step_q != '0))
        step_q <= step_q - 1'b1;

      if ((state_q == S_IDLE) || group_done) ret_q <= '0;
      else if (ret_ok)                       ret_q <= ret_q + 1'b1;

      in_valid_q <= (state_q == S_ISSUE);
      outst_q    <= outst_q + (STATE_W + 1)'(in_valid_q) - (STATE_W + 1)'(ret_ok);

      if (accept)        err_q <= 1'b0;
      else if (spurious) err_q <= 1'b1;

      if (accept) armed_q <= 1'b1;
    end
  end

  always_comb begin
    bus.busy          = (state_q == S_INIT) || (state_q == S_ISSUE) || (state_q == S_WAIT);
    bus.done          = (state_q == S_DONE);
    bus.err           = err_q;
    bus.init_we       = 1'b0;
    bus.init_state    = '0;
    bus.init_data     = '0;
    bus.init_step     = len_q;
    bus.rd_en         = 1'b0;
    bus.rd_step       = '0;
    bus.rd_state      = '0;
    bus.unit_in_valid = in_valid_q;
    bus.beta_we       = ret_ok;
    bus.llr_we        = ret_ok;
    bus.wr_step       = '0;
    bus.wr_state      = '0;
    bus.fsm_state     = state_q;

    if (state_q == S_INIT) begin
      bus.init_we    = 1'b1;
      bus.init_state = idx_q;
      bus.init_data  = ((idx_q == '0) || (TERMINATED == 0)) ? ONE : '0;
    end
    if (state_q == S_ISSUE) begin
      bus.rd_en    = 1'b1;
      bus.rd_step  = step_q;
      bus.rd_state = idx_q;
    end
    // Results land on the current step; the return counter names the state since the unit is in-order
    if (ret_ok) begin
      bus.wr_step  = step_q;
      bus.wr_state = ret_q[STATE_W-1:0];
    end
  end

endmodule

// File: tb/tb_max_product_beta_scheduler.sv
// Randomised bench for the beta scheduler: a fixed-latency unit model plus a scoreboard
// of expected init/read/write events and handoff timing derived from the block rules.
module tb_max_product_beta_scheduler;
  localparam int STATES  = 4;
  localparam int STEP_W  = 11;
  localparam int STATE_W = 2;
  localparam int BITS    = 32;
  localparam logic [31:0] ONE = 32'h3F80_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  max_product_beta_scheduler_if #(.STEP_W(STEP_W), .STATE_W(STATE_W), .BITS(BITS)) bus0 ();
  max_product_beta_scheduler_if #(.STEP_W(STEP_W), .STATE_W(STATE_W), .BITS(BITS)) bus1 ();

  max_product_beta_scheduler #(.STATES(STATES), .MAX_LEN(1024), .STEP_W(STEP_W),
    .STATE_W(STATE_W), .BITS(BITS), .TERMINATED(1)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  max_product_beta_scheduler #(.STATES(STATES), .MAX_LEN(1024), .STEP_W(STEP_W),
    .STATE_W(STATE_W), .BITS(BITS), .TERMINATED(0)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 3;
  bit mon_en = 0;
  bit inject = 0;
  int start_cyc, last_wr_cyc, issued, written, done_cnt, cur_len, stray_we, late_ret;
  bit first_grp;
  logic prev_rd = 1'b0;

  logic [STATE_W+31:0]       exp_init_q[$];
  logic [STEP_W+STATE_W-1:0] exp_rd_q[$];
  logic [STEP_W+STATE_W-1:0] exp_wr_q[$];
  int                        due_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  task automatic mon_cycle();
    logic [STATE_W+31:0]       ei;
    logic [STEP_W+STATE_W-1:0] e;
    if (bus0.init_we) begin
      if (exp_init_q.size() == 0) chk("init_extra", 1, 0);
      else begin
        ei = exp_init_q.pop_front();
        chk("init_write", {bus0.init_state, bus0.init_data}, ei);
        chk("init_step", bus0.init_step, cur_len);
      end
    end
    if (bus0.rd_en) begin
      if (bus0.rd_state == '0) begin
        chk("issue_dep", issued - written, 0);
        chk("issue_time", cyc, first_grp ? start_cyc + 5 : last_wr_cyc + 2);
        first_grp = 0;
      end
      if (exp_rd_q.size() == 0) chk("rd_extra", 1, 0);
      else begin
        e = exp_rd_q.pop_front();
        chk("rd_addr", {bus0.rd_step, bus0.rd_state}, e);
      end
      issued++;
    end
    if (bus0.unit_in_valid || prev_rd) chk("in_valid", bus0.unit_in_valid, prev_rd);
    if (bus0.beta_we || bus0.llr_we) begin
      chk("llr_we", bus0.llr_we, bus0.beta_we);
      if (exp_wr_q.size() == 0) chk("wr_extra", 1, 0);
      else begin
        e = exp_wr_q.pop_front();
        chk("wr_addr", {bus0.wr_step, bus0.wr_state}, e);
      end
      last_wr_cyc = cyc;
      written++;
    end
    if (bus0.done) begin
      done_cnt++;
      chk("done_busy", bus0.busy, 0);
      chk("done_time", cyc, (cur_len == 0) ? start_cyc + 5 : last_wr_cyc + 2);
    end
  endtask

  // Unit model: each in_valid seen in cycle k yields one out_valid in cycle k+lat
  initial begin
    bus0.unit_out_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus0.unit_out_valid = inject;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        bus0.unit_out_valid = 1'b1;
      end
      if (bus0.unit_in_valid) due_q.push_back(cyc + lat);
      @(negedge clk);
      if (mon_en) mon_cycle();
      else begin
        if (bus0.beta_we || bus0.llr_we) stray_we++;
        if (bus0.unit_out_valid) late_ret++;
      end
      prev_rd = bus0.rd_en;
    end
  end

  // Second instance (open-ended trellis): one-cycle loopback unit and an event recorder
  bit b1_en = 0;
  logic b1_pipe = 1'b0;
  logic [31:0] b1_init[$];
  logic [STEP_W+STATE_W-1:0] b1_rd[$];
  int b1_wr = 0;
  int b1_done = 0;
  initial begin
    bus1.unit_out_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus1.unit_out_valid = b1_pipe;
      b1_pipe = bus1.unit_in_valid;
    end
  end
  always @(negedge clk) begin
    if (b1_en) begin
      if (bus1.init_we) b1_init.push_back(bus1.init_data);
      if (bus1.rd_en) b1_rd.push_back({bus1.rd_step, bus1.rd_state});
      if (bus1.beta_we) b1_wr++;
      if (bus1.done) b1_done++;
    end
  end

  task automatic start_block(input int len, input int l);
    lat = l;
    cur_len = len;
    exp_init_q.delete();
    exp_rd_q.delete();
    exp_wr_q.delete();
    for (int s = 0; s < STATES; s++)
      exp_init_q.push_back({STATE_W'(s), (s == 0) ? ONE : 32'h0});
    for (int t = len - 1; t >= 0; t--)
      for (int s = 0; s < STATES; s++) begin
        exp_rd_q.push_back({STEP_W'(t), STATE_W'(s)});
        exp_wr_q.push_back({STEP_W'(t), STATE_W'(s)});
      end
    done_cnt = 0;
    issued = 0;
    written = 0;
    first_grp = 1;
    mon_en = 1;
    @(negedge clk);
    bus0.block_len = STEP_W'(len);
    bus0.start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    bus0.start = 1'b0;
    chk("busy_on", bus0.busy, 1);
    chk("err_clear", bus0.err, 0);
  endtask

  task automatic finish_block();
    int n = 0;
    int budget = 40 + cur_len * (lat + 12);
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", (done_cnt != 0), 1);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("busy_after", bus0.busy, 0);
    chk("init_left", exp_init_q.size(), 0);
    chk("rd_left", exp_rd_q.size(), 0);
    chk("wr_left", exp_wr_q.size(), 0);
    chk("err_block", bus0.err, 0);
  endtask

  task automatic run_block(input int len, input int l);
    start_block(len, l);
    finish_block();
  endtask

  initial begin
    int n;
    bus0.start = 1'b0;
    bus0.block_len = '0;
    bus1.start = 1'b0;
    bus1.block_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus0.busy, bus0.done, bus0.err, bus0.init_we, bus0.rd_en,
                     bus0.unit_in_valid, bus0.beta_we, bus0.llr_we}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", bus0.busy, 0);

    run_block(3, 3);
    run_block(0, 3);
    run_block(2, 10);
    repeat (4) run_block($urandom_range(1, 6), $urandom_range(1, 12));

    // Spurious result with nothing outstanding
    @(negedge clk);
    inject = 1'b1;
    @(negedge clk);
    #1;
    chk("spur_no_we", bus0.beta_we, 0);
    inject = 1'b0;
    @(negedge clk);
    chk("spur_err", bus0.err, 1);
    run_block(2, 4);

    // Reset in the middle of step 5 with two results in flight
    start_block(8, 3);
    n = 0;
    while (!(bus0.rd_en && bus0.rd_step == 11'd5 && bus0.rd_state == 2'd2) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_step5", (n < 400), 1);
    #2;
    mon_en = 0;
    stray_we = 0;
    late_ret = 0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_a", {bus0.busy, bus0.done, bus0.err, bus0.init_we, bus0.rd_en,
                      bus0.unit_in_valid, bus0.beta_we, bus0.llr_we, bus0.init_state,
                      bus0.rd_state, bus0.wr_state, bus0.init_step, bus0.rd_step, bus0.wr_step}, 0);
    chk("rst_mid_b", bus0.init_data, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("late_ret_seen", (late_ret > 0), 1);
    chk("late_we", stray_we, 0);
    chk("late_err", bus0.err, 0);
    run_block(8, 3);

    // Open-ended trellis, single step
    b1_en = 1;
    @(negedge clk);
    bus1.block_len = 11'd1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    n = 0;
    while (b1_done == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("b1_done", b1_done, 1);
    chk("b1_init_n", b1_init.size(), STATES);
    for (int s = 0; s < STATES && s < b1_init.size(); s++) chk("b1_init_data", b1_init[s], ONE);
    chk("b1_rd_n", b1_rd.size(), STATES);
    for (int s = 0; s < STATES && s < b1_rd.size(); s++)
      chk("b1_rd_addr", b1_rd[s], {11'd0, STATE_W'(s)});
    chk("b1_wr_n", b1_wr, STATES);
    chk("b1_err", bus1.err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_product_beta_scheduler.md
Name: max_product_beta_scheduler

Overview:
- Sequences the backward (beta) recursion of the max-product decoder over one trellis block.
- Time-multiplexes a single `max_product_symbol_state` pipeline across all STATES trellis states for each step, from t = block_len-1 down to 0.
- Generates metric-memory read addresses and the unit's `in_valid`, collects `out_valid` returns, and steers beta/LLR write-backs.
- Enforces the step-to-step data dependency: step t-1 is not issued until every beta of step t is written.

Parameters:
- STATES, 4, number of trellis states handled per step.
- MAX_LEN, 1024, maximum block length in trellis steps.
- STEP_W, $clog2(MAX_LEN+1), width of step indices.
- STATE_W, $clog2(STATES), width of state indices.
- BITS, 32, metric word width (IEEE single).
- TERMINATED, 1, 1 = trellis terminated in state 0; 0 = open-ended.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  begin a block; sampled only in IDLE.
- block_len  in  STEP_W  number of steps; latched on accepted start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at block completion.
- err  out  1  sticky protocol error.
- init_we  out  1  initial-beta write strobe.
- init_state  out  STATE_W  state index for the initial beta.
- init_data  out  BITS  initial beta value.
- init_step  out  STEP_W  equals the latched block_len.
- rd_en  out  1  metric read request (memory read latency is 1 cycle).
- rd_step  out  STEP_W  step t; the memory wrapper reads alpha/branch at t and old beta at t+1.
- rd_state  out  STATE_W  state index for the read.
- unit_in_valid  out  1  `in_valid` to the symbol-state unit; equals rd_en delayed by 1 cycle.
- unit_out_valid  in  1  `out_valid` from the unit.
- beta_we  out  1  beta write strobe.
- llr_we  out  1  LLR write strobe.
- wr_step  out  STEP_W  step index for the write.
- wr_state  out  STATE_W  state index for the write.

Behaviour:
- Reset (asynchronous, any time including mid-block):
  - FSM goes to IDLE; all counters clear.
  - Every output is 0.
  - In-flight unit results arriving after reset are ignored and do not set err.
- FSM states: IDLE, INIT, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 latches block_len and clears err; next state INIT, busy=1 from the next cycle.
  - start while busy is ignored.
- INIT:
  - Runs STATES cycles; init_we=1 and init_state=0..STATES-1 in order.
  - init_data = 32'h3F800000 (1.0) for state 0. Other states get 32'h00000000 if TERMINATED=1, else 1.0.
  - Then: if block_len==0, go to DONE; else set step=block_len-1 and go to ISSUE.
- ISSUE:
  - Runs STATES consecutive cycles with rd_en=1, rd_step=step, rd_state=0..STATES-1.
  - Returns may arrive concurrently. After the last issue, go to WAIT.
- Returns:
  - The unit is in-order with fixed latency.
  - Each unit_out_valid pulse gives beta_we=llr_we=1, combinationally in the same cycle, with wr_step=step and wr_state=return counter (0..STATES-1).
  - The return counter increments on each pulse.
- WAIT:
  - Leaves the cycle after the return counter reaches STATES (the STATES-th return may arrive during ISSUE).
  - If step==0, go to DONE. Otherwise step decrements, the return counter clears, and the FSM goes to ISSUE.
- DONE:
  - One cycle with done=1 and busy=0, then IDLE.
  - start in the DONE cycle is ignored.
- Outstanding count:
  - Incremented by unit_in_valid, decremented by unit_out_valid; both in one cycle leaves it unchanged.
  - unit_out_valid with outstanding==0 sets err; the return is not written.
  - err clears only on reset or an accepted start.
- Writes never target a step other than the current step. No new step is issued while outstanding>0.
- No arithmetic is performed on metric data; the block is a pure sequencer.

Test Plan:
- Reset-release: STATES=4, unit LAT=3, block_len=3, start pulse
  - -> 4 init writes at step 3 with data {1.0, 0, 0, 0}.
  - -> Issue groups for steps 2, 1, 0, each with rd_state 0,1,2,3.
  - -> 12 beta/llr writes with wr_step matching the issued group.
  - -> Exactly one done pulse, then busy=0.
- block_len=0 -> 4 init writes, no rd_en, done 5 cycles after start is accepted.
- TERMINATED=0, block_len=1 -> init_data=1.0 for all 4 states; one issue group at step 0.
- Unit model with LAT=10 (longer than STATES):
  - -> After each group, rd_en stays low until the 4th return.
  - -> Step 1 issue starts exactly 1 cycle after WAIT sees count 4.
- Spurious unit_out_valid while IDLE -> err=1, no beta_we; a later start clears err.
- reset_n low in the middle of step 5 of block_len=8:
  - -> All outputs 0 immediately.
  - -> Late returns ignored.
  - -> A fresh start runs a full block correctly.
